fifo_write_ctrl: RTL and testbench

Write-side pointer and flag controller of the asynchronous FIFO, sitting in the write clock domain upstream of the dual-port FIFO memory and the read-pointer synchronizer. Keeps the binary write pointer that addresses the memory and publishes a registered Gray-coded write pointer for crossing into the read domain. Uses the synchronized Gray read pointer to produce full, almost-full, fill-level and overflow indications.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_gray2bin.sv | 15 +
 rtl/fifo_write_ctrl.sv | 96 +++++++++
 tb/tb_fifo_write_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer widths and Gray/binary helpers for the async FIFO
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 3;
    localparam int FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int width);
        logic [31:0] gray;
        gray = bin ^ (bin >> 1);
        for (int i = 0; i < 32; i++) begin
            if (i >= width) gray[i] = 1'b0;
        end
        return gray;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
        logic [31:0] bin;
        logic        acc;
        bin = '0;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (i < width) begin
                acc    = acc ^ gray[i];
                bin[i] = acc;
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// rtl/fifo_gray2bin.sv - combinational Gray-to-binary converter (XOR prefix from the MSB)
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int W = FIFO_PTR_WIDTH
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[W-1:i];
    end

endmodule

// File: rtl/fifo_write_ctrl.sv
// rtl/fifo_write_ctrl.sv - write-domain pointer, full/almost-full/count flags of the async FIFO
// Optional sticky overflow flag built only when FIFO_WR_OVERFLOW_EN is defined.
module fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    input  logic                  wovf_clr,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wcount,
    output logic                  woverflow
);

    localparam int                PW        = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]     AFULL_THR = PW'(AFULL_LEVEL);

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wptr;
    logic          r_wfull;
    logic          r_walmost_full;
    logic [PW-1:0] r_wcount;

    logic          w_inc;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_rbin_sync;
    logic [PW-1:0] w_full_ptr;
    logic [PW-1:0] w_count_next;

    fifo_gray2bin #(.W(PW)) u_rptr_g2b (
        .i_gray (wq2_rptr),
        .o_bin  (w_rbin_sync)
    );

    assign w_inc        = winc & ~r_wfull;
    assign w_wbin_next  = r_wbin + {{ADDR_WIDTH{1'b0}}, w_inc};
    assign w_wgray_next = PW'(bin2gray(32'(w_wbin_next), PW));
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign w_full_ptr   = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
    assign w_count_next = w_wbin_next - w_rbin_sync;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wcount       <= '0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wptr         <= w_wgray_next;
            r_wfull        <= (w_wgray_next == w_full_ptr);
            r_walmost_full <= (w_count_next >= AFULL_THR);
            r_wcount       <= w_count_next;
        end
    end

`ifdef FIFO_WR_OVERFLOW_EN
    logic r_woverflow;

    // A fresh overflow takes priority over a clear in the same cycle.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_woverflow <= 1'b0;
        end else if (winc && r_wfull) begin
            r_woverflow <= 1'b1;
        end else if (wovf_clr) begin
            r_woverflow <= 1'b0;
        end
    end

    assign woverflow = r_woverflow;
`else
    logic w_unused_ovf_clr;

    assign w_unused_ovf_clr = wovf_clr;
    assign woverflow        = 1'b0;
`endif

    assign wen          = w_inc;
    assign waddr        = r_wbin[ADDR_WIDTH-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wcount       = r_wcount;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb/tb_fifo_write_ctrl.sv - randomized self-checking bench for fifo_write_ctrl against an occupancy model
module tb_fifo_write_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int AFULL = 6;
`ifdef FIFO_WR_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          winc;
    logic [AW:0]   wq2_rptr;
    logic          wovf_clr;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wcount;
    logic          woverflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: total writes accepted, read pointer as seen by wclk, flags.
    int m_wr;
    int m_rd;
    bit m_full;
    bit m_ovf;

    fifo_write_ctrl #(.ADDR_WIDTH(AW), .AFULL_LEVEL(AFULL)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wovf_clr     (wovf_clr),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wcount       (wcount),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [AW:0] gray(input int b);
        int x;
        x = b % (2 * DEPTH);
        return (AW+1)'(x ^ (x >> 1));
    endfunction

    function automatic int fill();
        return m_wr - m_rd;
    endfunction

    task automatic drive(input logic inc, input int rd, input logic clr);
        winc     = inc;
        m_rd     = rd;
        wq2_rptr = gray(rd);
        wovf_clr = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge wclk);
        if (OVF_EN) begin
            if (winc && m_full) m_ovf = 1'b1;
            else if (wovf_clr)  m_ovf = 1'b0;
        end
        if (winc && !m_full) m_wr++;
        m_full = (fill() == DEPTH);
        @(negedge wclk);
    endtask

    task automatic apply_reset();
        wrst_n = 1'b0;
        m_wr = 0; m_rd = 0; m_full = 1'b0; m_ovf = 1'b0;
        drive(1'b0, 0, 1'b0);
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        wrst_n = 1'b0;
        drive(1'b1, 0, 1'b0);
        n_tests++; if (wptr !== 4'h0)   begin n_fail++; $display("FAIL reset_wptr: got %h want 0", wptr); end
        n_tests++; if (wfull !== 1'b0)  begin n_fail++; $display("FAIL reset_wfull: got %b want 0", wfull); end
        n_tests++; if (walmost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b want 0", walmost_full); end
        n_tests++; if (wcount !== 4'h0) begin n_fail++; $display("FAIL reset_wcount: got %h want 0", wcount); end
        n_tests++; if (woverflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", woverflow); end
        n_tests++; if (wen !== 1'b1)    begin n_fail++; $display("FAIL reset_wen: got %b want 1", wen); end
        n_tests++; if (waddr !== 3'h0)  begin n_fail++; $display("FAIL reset_waddr: got %h want 0", waddr); end
        apply_reset();
    endtask

    task automatic test_fill();
        logic [AW:0] gseq [0:DEPTH];
        gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 0, 1'b0);
            n_tests++; if (waddr !== AW'(i)) begin n_fail++; $display("FAIL fill_waddr[%0d]: got %0d want %0d", i, waddr, i); end
            n_tests++; if (wen !== 1'b1) begin n_fail++; $display("FAIL fill_wen[%0d]: got %b want 1", i, wen); end
            tick();
            n_tests++; if (wptr !== gseq[i+1]) begin n_fail++; $display("FAIL fill_wptr[%0d]: got %h want %h", i, wptr, gseq[i+1]); end
            n_tests++; if (wcount !== (AW+1)'(i+1)) begin n_fail++; $display("FAIL fill_wcount[%0d]: got %0d want %0d", i, wcount, i+1); end
            n_tests++; if (walmost_full !== (i+1 >= AFULL)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b want %b", i, walmost_full, i+1 >= AFULL); end
            n_tests++; if (wfull !== (i == DEPTH-1)) begin n_fail++; $display("FAIL fill_wfull[%0d]: got %b want %b", i, wfull, i == DEPTH-1); end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, 1'b0);
            n_tests++; if (wen !== 1'b0) begin n_fail++; $display("FAIL ovf_wen[%0d]: got %b want 0", i, wen); end
            tick();
            n_tests++; if (wptr !== 4'hC) begin n_fail++; $display("FAIL ovf_wptr[%0d]: got %h want c", i, wptr); end
            n_tests++; if (wcount !== 4'd8) begin n_fail++; $display("FAIL ovf_wcount[%0d]: got %0d want 8", i, wcount); end
            n_tests++; if (woverflow !== OVF_EN) begin n_fail++; $display("FAIL ovf_flag[%0d]: got %b want %b", i, woverflow, OVF_EN); end
        end
    endtask

    task automatic test_ovf_clr();
        drive(1'b1, 0, 1'b1);
        tick();
        n_tests++; if (woverflow !== OVF_EN) begin n_fail++; $display("FAIL ovfclr_race: got %b want %b", woverflow, OVF_EN); end
        drive(1'b0, 0, 1'b1);
        tick();
        n_tests++; if (woverflow !== 1'b0) begin n_fail++; $display("FAIL ovfclr_clear: got %b want 0", woverflow); end
    endtask

    task automatic test_release();
        drive(1'b0, 1, 1'b0);
        tick();
        n_tests++; if (wfull !== 1'b0) begin n_fail++; $display("FAIL rel_wfull: got %b want 0", wfull); end
        n_tests++; if (wcount !== 4'd7) begin n_fail++; $display("FAIL rel_wcount: got %0d want 7", wcount); end
        drive(1'b1, 1, 1'b0);
        n_tests++; if (wen !== 1'b1) begin n_fail++; $display("FAIL rel_wen: got %b want 1", wen); end
        tick();
        n_tests++; if (wcount !== 4'd8 || wfull !== 1'b1) begin n_fail++; $display("FAIL rel_refill: got count %0d full %b want 8 1", wcount, wfull); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, 1'b0);
            tick();
        end
        #2;
        wrst_n = 1'b0;
        m_wr = 0; m_rd = 0; m_full = 1'b0; m_ovf = 1'b0;
        #1;
        n_tests++; if ({wptr, wcount, wfull, walmost_full, woverflow} !== 11'd0) begin n_fail++; $display("FAIL arst_outputs: got wptr %h wcount %0d full %b afull %b ovf %b want all 0", wptr, wcount, wfull, walmost_full, woverflow); end
        n_tests++; if (waddr !== 3'd0 || wen !== 1'b1) begin n_fail++; $display("FAIL arst_comb: got waddr %0d wen %b want 0 1", waddr, wen); end
        @(negedge wclk);
        wrst_n = 1'b1;
        drive(1'b1, 0, 1'b0);
        n_tests++; if (waddr !== 3'd0) begin n_fail++; $display("FAIL arst_resume_addr: got %0d want 0", waddr); end
        tick();
        n_tests++; if (wptr !== 4'h1 || wcount !== 4'd1) begin n_fail++; $display("FAIL arst_resume: got wptr %h wcount %0d want 1 1", wptr, wcount); end
    endtask

    task automatic test_wrap();
        int wr_d1, wr_d2, max_cnt, full_seen;
        apply_reset();
        wr_d1 = 0; wr_d2 = 0; max_cnt = 0; full_seen = 0;
        for (int i = 0; i < 22; i++) begin
            drive(i < 20, wr_d2, 1'b0);
            tick();
            wr_d2 = wr_d1;
            wr_d1 = m_wr;
            if (wfull) full_seen++;
            if (int'(wcount) > max_cnt) max_cnt = int'(wcount);
            n_tests++; if (wptr !== gray(m_wr)) begin n_fail++; $display("FAIL wrap_wptr[%0d]: got %h want %h", i, wptr, gray(m_wr)); end
        end
        n_tests++; if (full_seen != 0) begin n_fail++; $display("FAIL wrap_full: got %0d full cycles want 0", full_seen); end
        n_tests++; if (max_cnt > 3) begin n_fail++; $display("FAIL wrap_count: got max %0d want <=3", max_cnt); end
        n_tests++; if (m_wr != 20 || wptr !== gray(20)) begin n_fail++; $display("FAIL wrap_total: got wptr %h want %h", wptr, gray(20)); end
    endtask

    task automatic test_random();
        int wr_d1, wr_d2, rd;
        logic inc, clr;
        apply_reset();
        wr_d1 = 0; wr_d2 = 0; rd = 0;
        for (int i = 0; i < 400; i++) begin
            inc = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 9) == 0);
            if (rd < wr_d2 && $urandom_range(0, 2) == 0) rd++;
            drive(inc, rd, clr);
            n_tests++; if (wen !== (inc && !m_full)) begin n_fail++; $display("FAIL rnd_wen[%0d]: got %b want %b", i, wen, inc && !m_full); end
            tick();
            wr_d2 = wr_d1;
            wr_d1 = m_wr;
            n_tests++;
            if (wptr !== gray(m_wr) || wcount !== (AW+1)'(fill()) || wfull !== m_full ||
                walmost_full !== (fill() >= AFULL) || waddr !== AW'(m_wr % DEPTH) || woverflow !== m_ovf) begin
                n_fail++;
                $display("FAIL rnd_state[%0d]: got wptr %h cnt %0d full %b afull %b addr %0d ovf %b want %h %0d %b %b %0d %b",
                         i, wptr, wcount, wfull, walmost_full, waddr, woverflow,
                         gray(m_wr), fill(), m_full, fill() >= AFULL, m_wr % DEPTH, m_ovf);
            end
        end
    endtask

    initial begin
        wrst_n = 1'b0; winc = 1'b0; wq2_rptr = '0; wovf_clr = 1'b0;
        m_wr = 0; m_rd = 0; m_full = 1'b0; m_ovf = 1'b0;
        @(negedge wclk);
        test_reset();
        test_fill();
        test_overflow();
        test_ovf_clr();
        test_release();
        test_async_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
